// File: rtl/if_stage_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package if_stage_pkg;

    localparam int          INSTRUCTION_SIZE = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        IF_FETCH = 2'b00,
        IF_WAIT  = 2'b01,
        IF_DROP  = 2'b10
    } if_state_e;

    typedef struct packed {
        logic [31:0]                 pc;
        logic [INSTRUCTION_SIZE-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_stage_fetch_buffer.sv
// Small flushable FIFO of {pc, instr}; head is read combinationally.
module fetch_buffer
    import if_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  logic [31:0]                 push_pc_i,
    input  logic [INSTRUCTION_SIZE-1:0] push_instr_i,
    input  logic                        pop_i,
    output logic [CW-1:0]               count_o,
    output logic [31:0]                 head_pc_o,
    output logic [INSTRUCTION_SIZE-1:0] head_instr_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= '{pc: push_pc_i, instr: push_instr_i};
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_i) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign count_o      = cnt_q;
    assign head_pc_o    = mem_q[rd_q].pc;
    assign head_instr_o = mem_q[rd_q].instr;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one request at a time to
// instruction memory, buffers responses for decode, and handles redirects.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] fetch_pc_debug
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    if_state_e     state_q;
    logic [31:0]   fetch_pc_q, req_pc_q;
    logic [CW-1:0] count;
    logic [31:0]   head_pc, head_instr;
    logic          buf_empty, req_hs, push, pop;

    assign buf_empty      = (count == '0);
    assign imem_req_valid = rst && (state_q == IF_FETCH) && (count < CW'(BUF_DEPTH))
                            && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_hs         = imem_req_valid && imem_req_ready;
    // A response coinciding with a redirect belongs to the old path.
    assign push           = (state_q == IF_WAIT) && imem_rsp_valid && !redirect_valid;

    assign id_valid       = rst && !buf_empty && !redirect_valid;
    assign pop            = id_valid && id_ready;
    assign id_instr       = (rst && !buf_empty) ? head_instr : NOP_INSTR;
    assign id_pc          = (rst && !buf_empty) ? head_pc : 32'h0;
    assign fetch_pc_debug = fetch_pc_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IF_FETCH;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            unique case (state_q)
                IF_FETCH: if (req_hs) begin
                    state_q    <= IF_WAIT;
                    req_pc_q   <= fetch_pc_q;
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                IF_WAIT: begin
                    if (imem_rsp_valid)      state_q <= IF_FETCH;
                    else if (redirect_valid) state_q <= IF_DROP;
                end
                IF_DROP: if (imem_rsp_valid) state_q <= IF_FETCH;
                default: state_q <= IF_FETCH;
            endcase
            if (redirect_valid) fetch_pc_q <= {redirect_pc[31:2], 2'b00};
        end
    end

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (redirect_valid),
        .push_i       (push),
        .push_pc_i    (req_pc_q),
        .push_instr_i (imem_rsp_data),
        .pop_i        (pop),
        .count_o      (count),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr)
    );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a latency-randomized memory and a queue-level model of
// the decode-visible stream, plus directed redirect/reset/wrap scenarios.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc, fetch_pc_debug;

    if_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .fetch_pc_debug (fetch_pc_debug)
    );

    always #5 clk = ~clk;

    int          n_cmp, n_err;
    // Reference model: buffered PCs in order, expected fetch address, memory.
    logic [31:0] q_pc[$];
    logic [31:0] exp_fetch;
    bit          pend, stale;
    logic [31:0] pend_addr;
    int          rem;
    int          k_lo, k_hi;
    int          n_acc, n_pop;
    logic [31:0] acc_log[$], pop_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: drive inputs, check outputs at negedge, advance the model.
    task automatic step(input bit rdy, input bit rdr, input logic [31:0] rpc, input bit idr);
        bit rsp, exp_rv, exp_iv, hs;
        if (pend) rem--;
        rsp            = pend && (rem <= 0);
        imem_req_ready = rdy;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(pend_addr) : $urandom;
        redirect_valid = rdr && rst;
        redirect_pc    = rpc;
        id_ready       = idr;
        @(negedge clk);
        if (!rst) begin
            n_cmp++;
            if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'h0) begin
                n_err++;
                $display("FAIL reset_outputs: req_valid=%b id_valid=%b instr=%h pc=%h, want 0 0 %h 0",
                         imem_req_valid, id_valid, id_instr, id_pc, NOP);
            end
            if (rsp) pend = 0;
            q_pc.delete();
            exp_fetch = RST_PC;
            stale     = 0;
        end else begin
            exp_rv = !pend && (q_pc.size() < DEPTH) && !rdr;
            exp_iv = (q_pc.size() != 0) && !rdr;
            n_cmp++;
            if (imem_req_valid !== exp_rv) begin
                n_err++;
                $display("FAIL req_valid: got %b want %b (t=%0t)", imem_req_valid, exp_rv, $time);
            end
            if (exp_rv) begin
                n_cmp++;
                if (imem_req_addr !== exp_fetch) begin
                    n_err++;
                    $display("FAIL req_addr: got %h want %h (t=%0t)", imem_req_addr, exp_fetch, $time);
                end
            end
            n_cmp++;
            if (fetch_pc_debug !== exp_fetch) begin
                n_err++;
                $display("FAIL fetch_pc: got %h want %h (t=%0t)", fetch_pc_debug, exp_fetch, $time);
            end
            n_cmp++;
            if (id_valid !== exp_iv) begin
                n_err++;
                $display("FAIL id_valid: got %b want %b (t=%0t)", id_valid, exp_iv, $time);
            end
            n_cmp++;
            if (q_pc.size() != 0) begin
                if (id_pc !== q_pc[0] || id_instr !== mem_word(q_pc[0])) begin
                    n_err++;
                    $display("FAIL id_head: got pc=%h instr=%h want pc=%h instr=%h",
                             id_pc, id_instr, q_pc[0], mem_word(q_pc[0]));
                end
            end else if (id_pc !== 32'h0 || id_instr !== NOP) begin
                n_err++;
                $display("FAIL id_empty: got pc=%h instr=%h want 0 %h", id_pc, id_instr, NOP);
            end
            n_cmp++;
            if (dut.push && dut.count == DEPTH) begin
                n_err++;
                $display("FAIL push_full: push with count=%0d want count<%0d", dut.count, DEPTH);
            end
            hs = exp_rv && rdy;
            if (exp_iv && idr) begin
                pop_log.push_back(q_pc[0]);
                void'(q_pc.pop_front());
                n_pop++;
            end
            if (rsp) begin
                if (!stale && !rdr) q_pc.push_back(pend_addr);
                pend  = 0;
                stale = 0;
            end
            if (hs) begin
                pend      = 1;
                pend_addr = exp_fetch;
                rem       = $urandom_range(k_hi, k_lo);
                exp_fetch = exp_fetch + 32'd4;
                n_acc++;
                acc_log.push_back(pend_addr);
            end
            if (rdr) begin
                q_pc.delete();
                exp_fetch = {rpc[31:2], 2'b00};
                if (pend) stale = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        for (int i = 0; i < cycles; i++) step($urandom_range(1, 0), 0, 32'h0, $urandom_range(1, 0));
        pend  = 0;
        stale = 0;
        rst   = 1'b1;
        acc_log.delete();
        pop_log.delete();
    endtask

    task automatic test_reset();
        k_lo = 1; k_hi = 1;
        do_reset(3);
        step(1, 0, 32'h0, 0);
        n_cmp++;
        if (acc_log.size() != 1 || acc_log[0] !== RST_PC) begin
            n_err++;
            $display("FAIL reset_first_req: accepts=%0d want 1 at %h", acc_log.size(), RST_PC);
        end
    endtask

    task automatic test_stream();
        int a0, p0;
        k_lo = 1; k_hi = 1;
        do_reset(2);
        a0 = n_acc; p0 = n_pop;
        for (int i = 0; i < 12; i++) step(1, 0, 32'h0, 1);
        n_cmp++;
        if (n_acc - a0 != 6 || n_pop - p0 != 5) begin
            n_err++;
            $display("FAIL stream_rate: accepts=%0d pops=%0d want 6 5", n_acc - a0, n_pop - p0);
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (pop_log.size() <= i || pop_log[i] !== 32'(4 * i)) begin
                n_err++;
                $display("FAIL stream_pc[%0d]: got %h want %h", i,
                         (pop_log.size() > i) ? pop_log[i] : 32'hx, 32'(4 * i));
            end
        end
    endtask

    task automatic test_backpressure();
        k_lo = 1; k_hi = 1;
        do_reset(2);
        for (int i = 0; i < 10; i++) step(1, 0, 32'h0, 0);
        n_cmp++;
        if (imem_req_valid !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h0) begin
            n_err++;
            $display("FAIL bp_full: req_valid=%b id_valid=%b id_pc=%h want 0 1 0",
                     imem_req_valid, id_valid, id_pc);
        end
        for (int i = 0; i < 8; i++) step(1, 0, 32'h0, 1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (pop_log.size() <= i || pop_log[i] !== 32'(4 * i)) begin
                n_err++;
                $display("FAIL bp_drain[%0d]: pops=%0d want pc %h", i, pop_log.size(), 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_wait();
        k_lo = 3; k_hi = 3;
        do_reset(2);
        step(1, 0, 32'h0, 1);
        step(1, 0, 32'h0, 1);
        acc_log.delete();
        pop_log.delete();
        step(1, 1, 32'h0000_0100, 1);
        for (int i = 0; i < 12; i++) step(1, 0, 32'h0, 1);
        n_cmp++;
        if (acc_log.size() == 0 || acc_log[0] !== 32'h100) begin
            n_err++;
            $display("FAIL rw_req: accepts=%0d want first at 00000100", acc_log.size());
        end
        n_cmp++;
        if (pop_log.size() == 0 || pop_log[0] !== 32'h100) begin
            n_err++;
            $display("FAIL rw_first_pc: pops=%0d want first 00000100", pop_log.size());
        end
    endtask

    task automatic test_redirect_rsp();
        k_lo = 1; k_hi = 1;
        do_reset(2);
        step(1, 0, 32'h0, 0);
        step(1, 0, 32'h0, 0);
        k_lo = 2; k_hi = 2;
        step(1, 0, 32'h0, 0);
        step(1, 0, 32'h0, 0);
        acc_log.delete();
        step(1, 1, 32'h0000_0200, 1);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        #1;
        n_cmp++;
        if (id_valid !== 1'b0 || fetch_pc_debug !== 32'h200) begin
            n_err++;
            $display("FAIL rr_flush: id_valid=%b fetch_pc=%h want 0 00000200", id_valid, fetch_pc_debug);
        end
        for (int i = 0; i < 4; i++) step(1, 0, 32'h0, 1);
        n_cmp++;
        if (acc_log.size() == 0 || acc_log[0] !== 32'h200) begin
            n_err++;
            $display("FAIL rr_req: accepts=%0d want first at 00000200", acc_log.size());
        end
    endtask

    task automatic test_wrap();
        k_lo = 1; k_hi = 1;
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 32'h0, 1);
            n_cmp++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
                n_err++;
                $display("FAIL stall_addr[%0d]: valid=%b addr=%h want 1 %h", i, imem_req_valid, imem_req_addr, RST_PC);
            end
        end
        step(0, 1, 32'hFFFF_FFFD, 1);
        for (int i = 0; i < 8; i++) step(1, 0, 32'h0, 1);
        n_cmp++;
        if (acc_log.size() < 2 || acc_log[0] !== 32'hFFFF_FFFC || acc_log[1] !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_addr: accepts=%0d want FFFFFFFC then 00000000", acc_log.size());
        end
        n_cmp++;
        if (pop_log.size() < 2 || pop_log[0] !== 32'hFFFF_FFFC || pop_log[1] !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_pc: pops=%0d want FFFFFFFC then 00000000", pop_log.size());
        end
    endtask

    task automatic test_reset_wait();
        k_lo = 2; k_hi = 2;
        do_reset(2);
        step(1, 0, 32'h0, 1);
        step(1, 0, 32'h0, 1);
        step(1, 0, 32'h0, 1);
        step(1, 0, 32'h0, 1);
        do_reset(2);
        step(1, 0, 32'h0, 1);
        n_cmp++;
        if (acc_log.size() != 1 || acc_log[0] !== RST_PC || id_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_wait: accepts=%0d id_valid=%b want 1 at %h, 0", acc_log.size(), id_valid, RST_PC);
        end
        for (int i = 0; i < 6; i++) step(1, 0, 32'h0, 1);
        n_cmp++;
        if (pop_log.size() == 0 || pop_log[0] !== RST_PC) begin
            n_err++;
            $display("FAIL rst_wait_pc: pops=%0d want first %h", pop_log.size(), RST_PC);
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        k_lo = 1; k_hi = 3;
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(999, 0) < 4) do_reset($urandom_range(3, 1));
            tgt = ($urandom_range(9, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
            step($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 4, tgt, $urandom_range(99, 0) < 60);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_acc = 0; n_pop = 0;
        rst = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        pend = 0; stale = 0; rem = 0; exp_fetch = RST_PC;
        k_lo = 1; k_hi = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rsp();
        test_wrap();
        test_reset_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
